// File: rtl/mac_pkg.sv
// Shared definitions for the systolic MAC column: instruction bit positions,
// load-FSM state encoding and default geometry.
package mac_pkg;

    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;
    localparam int INST_ACC  = 2;
    localparam int INST_W    = 3;

    localparam int BW_DEF      = 8;
    localparam int PR_DEF      = 8;
    localparam int COL_NUM_DEF = 8;

    typedef enum logic [1:0] {
        LD_ARM   = 2'd0,
        LD_COUNT = 2'd1,
        LD_HOLD  = 2'd2
    } ld_state_e;

endpackage

// File: rtl/mac_dot.sv
// Signed pr-lane dot product, purely combinational, result sign-extended to bw_psum.
module mac_dot
    import mac_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int pr      = PR_DEF,
    parameter int bw_psum = 2*bw+6
) (
    input  logic [pr*bw-1:0]   a_i,
    input  logic [pr*bw-1:0]   b_i,
    output logic [bw_psum-1:0] psum_o
);

    logic signed [2*bw-1:0] prod [pr];
    logic [bw_psum-1:0]     sum;

    for (genvar i = 0; i < pr; i++) begin : g_lane
        assign prod[i] = $signed(a_i[i*bw +: bw]) * $signed(b_i[i*bw +: bw]);
    end

    // Sum the sign-extended lane products.
    always_comb begin
        sum = '0;
        for (int i = 0; i < pr; i++) begin
            sum = sum + {{(bw_psum-2*bw){prod[i][2*bw-1]}}, prod[i]};
        end
    end

    assign psum_o = sum;

endmodule

// File: rtl/mac_col_mk.sv
// Systolic MAC column: forwards queries/instructions to the next column, loads
// its own key vector in its time slot, and computes/accumulates dot products.
// Optional feature macro: MAC_COL_ACC_SAT_EN (saturating accumulate, sticky o_sat).
//
// state    | meaning
// LD_ARM   | idle, waiting for the first load cycle of a burst
// LD_COUNT | counting load cycles until this column's slot comes round
// LD_HOLD  | key captured; ignore the rest of the burst
module mac_col_mk
    import mac_pkg::*;
#(
    parameter int bw       = BW_DEF,
    parameter int bw_psum  = 2*bw+6,
    parameter int bw_acc   = bw_psum+4,
    parameter int pr       = PR_DEF,
    parameter int col_num  = COL_NUM_DEF,
    parameter int col_id   = 0,
    parameter int N_KEY    = 2,
    localparam int KW      = (N_KEY > 1) ? $clog2(N_KEY) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [pr*bw-1:0]  q_in,
    input  logic [INST_W-1:0] i_inst,
    input  logic [KW-1:0]     i_ksel,
    output logic [pr*bw-1:0]  q_out,
    output logic [INST_W-1:0] o_inst,
    output logic [KW-1:0]     o_ksel,
    output logic [bw_acc-1:0] out,
    output logic              fifo_wr,
    output logic              o_sat
);

    localparam int            CW     = $clog2(col_num) + 1;
    localparam int            SLOT   = col_num - 1 - col_id;
    localparam logic [CW-1:0] SLOT_C = CW'(SLOT);

    logic [INST_W-1:0] inst_q, inst_2q;
    logic [1:0]        inst_3q;
    logic [KW-1:0]     ksel_q, ksel_2q;
    logic [pr*bw-1:0]  query_q;
    logic [pr*bw-1:0]  key_q [N_KEY];
    logic [CW-1:0]     cnt_q, cnt_d;
    ld_state_e         state_q, state_d;
    logic              key_we;
    logic [bw_acc-1:0] acc_q, acc_d;
    logic [bw_psum-1:0] psum;
    logic [bw_acc-1:0] psum_ext;
    logic [pr*bw-1:0]  key_sel;
    logic              exec_fire;

    // Instruction/select pipeline and query forwarding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q  <= '0;
            inst_2q <= '0;
            inst_3q <= '0;
            ksel_q  <= '0;
            ksel_2q <= '0;
            query_q <= '0;
        end else begin
            inst_q  <= i_inst;
            ksel_q  <= i_ksel;
            inst_2q <= inst_q;
            ksel_2q <= ksel_q;
            inst_3q <= inst_2q[1:0];
            if (inst_q[1:0] != 2'b00) begin
                query_q <= q_in;
            end
        end
    end

    // Load FSM state and slot counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LD_ARM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load FSM next state: count load cycles and capture the key at this column's slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_we  = 1'b0;
        if (inst_q[INST_LOAD]) begin
            case (state_q)
                LD_ARM: begin
                    cnt_d = CW'(1);
                    if (SLOT == 0) begin
                        key_we  = 1'b1;
                        state_d = LD_HOLD;
                    end else begin
                        state_d = LD_COUNT;
                    end
                end
                LD_COUNT: begin
                    if (cnt_q == SLOT_C) begin
                        key_we  = 1'b1;
                        state_d = LD_HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                LD_HOLD: begin
                    state_d = LD_HOLD;
                end
                default: begin
                    state_d = LD_ARM;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            cnt_d   = '0;
            state_d = LD_ARM;
        end
    end

    // Key banks; written only on the slot cycle of a load burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_KEY; i++) begin
                key_q[i] <= '0;
            end
        end else if (key_we) begin
            key_q[ksel_q] <= q_in;
        end
    end

    assign key_sel   = key_q[ksel_2q];
    assign exec_fire = inst_2q[INST_EXEC] & ~inst_2q[INST_LOAD];

    mac_dot #(
        .bw      (bw),
        .pr      (pr),
        .bw_psum (bw_psum)
    ) u_dot (
        .a_i    (query_q),
        .b_i    (key_sel),
        .psum_o (psum)
    );

    assign psum_ext = {{(bw_acc-bw_psum){psum[bw_psum-1]}}, psum};

`ifdef MAC_COL_ACC_SAT_EN
    localparam logic [bw_acc-1:0] ACC_MAX = {1'b0, {(bw_acc-1){1'b1}}};
    localparam logic [bw_acc-1:0] ACC_MIN = {1'b1, {(bw_acc-1){1'b0}}};

    logic [bw_acc:0] sum_w;
    logic            sat_q, sat_d;

    // Accumulator next value with clamping; the extra sum bit exposes overflow.
    always_comb begin
        sum_w = {acc_q[bw_acc-1], acc_q} + {psum_ext[bw_acc-1], psum_ext};
        acc_d = acc_q;
        sat_d = sat_q;
        if (exec_fire) begin
            if (inst_2q[INST_ACC]) begin
                if (sum_w[bw_acc] != sum_w[bw_acc-1]) begin
                    acc_d = sum_w[bw_acc] ? ACC_MIN : ACC_MAX;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum_w[bw_acc-1:0];
                end
            end else begin
                acc_d = psum_ext;
            end
        end
    end

    // Sticky saturation flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign o_sat = sat_q;
`else
    // Accumulator next value with two's-complement wrap.
    always_comb begin
        acc_d = acc_q;
        if (exec_fire) begin
            acc_d = inst_2q[INST_ACC] ? (acc_q + psum_ext) : psum_ext;
        end
    end

    assign o_sat = 1'b0;
`endif

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out     = acc_q;
    assign fifo_wr = inst_3q[INST_EXEC] & ~inst_3q[INST_LOAD];
    assign q_out   = query_q;
    assign o_inst  = inst_q;
    assign o_ksel  = ksel_q;

endmodule

// File: tb/tb_mac_col_mk.sv
// Scoreboard bench for mac_col_mk (col_id=2 of 8, two key banks).
module tb_mac_col_mk;

    localparam int BW      = 8;
    localparam int PR      = 8;
    localparam int BW_PSUM = 22;
    localparam int BW_ACC  = 26;
    localparam int COL_NUM = 8;
    localparam int COL_ID  = 2;
    localparam int N_KEY   = 2;
    localparam longint ACC_MAX = 64'sd33554431;
    localparam longint ACC_MIN = -64'sd33554432;

    logic              clk;
    logic              reset;
    logic [63:0]       q_in;
    logic [2:0]        i_inst;
    logic [0:0]        i_ksel;
    logic [63:0]       q_out;
    logic [2:0]        o_inst;
    logic [0:0]        o_ksel;
    logic [BW_ACC-1:0] out;
    logic              fifo_wr;
    logic              o_sat;

    mac_col_mk #(
        .bw      (BW),
        .bw_psum (BW_PSUM),
        .bw_acc  (BW_ACC),
        .pr      (PR),
        .col_num (COL_NUM),
        .col_id  (COL_ID),
        .N_KEY   (N_KEY)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .q_in    (q_in),
        .i_inst  (i_inst),
        .i_ksel  (i_ksel),
        .q_out   (q_out),
        .o_inst  (o_inst),
        .o_ksel  (o_ksel),
        .out     (out),
        .fifo_wr (fifo_wr),
        .o_sat   (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW_ACC-1:0] exp;
        int                due;
    } sb_t;

    sb_t                sb [$];
    int                 n_chk = 0;
    int                 n_err = 0;
    int                 cyc   = 0;
    logic [63:0]        q_pend;
    logic [63:0]        qout_m;
    logic [2:0]         inst_m;
    logic [63:0]        mkey [2];
    logic signed [BW_ACC-1:0] m_acc;
    logic               m_sat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fill(input logic [7:0] v);
        logic [63:0] r;
        for (int i = 0; i < PR; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic longint dot(input logic [63:0] q, input logic [63:0] k);
        longint s;
        logic signed [7:0] a, b;
        s = 0;
        for (int i = 0; i < PR; i++) begin
            a = q[i*8 +: 8];
            b = k[i*8 +: 8];
            s = s + longint'(a) * longint'(b);
        end
        return s;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_acc   = '0;
        m_sat   = 1'b0;
        mkey[0] = '0;
        mkey[1] = '0;
        qout_m  = '0;
        inst_m  = '0;
        q_pend  = '0;
    endtask

    // One clock: drive inst/ksel now, the data word one cycle later; check on the far side of the edge.
    task automatic step(input logic [2:0] inst, input logic ksel, input logic [63:0] qd);
        logic [63:0] q_cur;
        longint      p;
        longint      s;
        q_cur  = q_pend;
        i_inst = inst;
        i_ksel = ksel;
        q_in   = q_cur;
        q_pend = qd;
        if (inst[1] && !inst[0]) begin
            p = dot(qd, mkey[ksel]);
            if (inst[2]) begin
                s = longint'(m_acc) + p;
`ifdef MAC_COL_ACC_SAT_EN
                if (s > ACC_MAX) begin
                    s = ACC_MAX;
                    m_sat = 1'b1;
                end else if (s < ACC_MIN) begin
                    s = ACC_MIN;
                    m_sat = 1'b1;
                end
`endif
            end else begin
                s = p;
            end
            m_acc = s[BW_ACC-1:0];
            sb.push_back('{exp: m_acc, due: cyc + 3});
        end
        @(posedge clk);
        cyc++;
        if (inst_m[1:0] != 2'b00) qout_m = q_cur;
        inst_m = inst;
        #1;
        chk("o_inst", {61'd0, o_inst}, {61'd0, inst});
        chk("o_ksel", {63'd0, o_ksel}, {63'd0, ksel});
        chk("q_out", q_out, qout_m);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("fifo_wr_due", {63'd0, fifo_wr}, 64'd1);
            chk("out", {38'd0, out}, {38'd0, sb[0].exp});
            void'(sb.pop_front());
        end else begin
            chk("fifo_wr_idle", {63'd0, fifo_wr}, 64'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b0, 64'd0);
    endtask

    // Load burst of n cycles; cycle 5 carries v, the others carry their own index.
    task automatic load_seq(input logic bank, input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            step(3'b001, bank, (k == 5) ? v : fill(8'(k)));
        end
        if (n >= 6) mkey[bank] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycles=%0d limit=100000ns", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        i_inst = '0;
        i_ksel = '0;
        q_in   = '0;
        model_reset();
        #1;
        chk("rst_out", {38'd0, out}, 64'd0);
        chk("rst_fifo_wr", {63'd0, fifo_wr}, 64'd0);
        chk("rst_q_out", q_out, 64'd0);
        chk("rst_o_inst", {61'd0, o_inst}, 64'd0);
        chk("rst_o_sat", {63'd0, o_sat}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        // Slot capture on load cycle 5, HOLD through cycles 6..7; first op is an accumulate from zero.
        load_seq(1'b0, fill(8'd5), 8);
        idle(1);
        step(3'b110, 1'b0, fill(8'd1));
        idle(4);

        // Basic execute then back-to-back accumulates.
        load_seq(1'b0, fill(8'd1), 8);
        idle(1);
        step(3'b010, 1'b0, fill(8'd3));
        step(3'b110, 1'b0, fill(8'd3));
        step(3'b110, 1'b0, fill(8'd3));
        step(3'b110, 1'b0, fill(8'd3));
        idle(4);

        // Two key banks, opposite signs.
        load_seq(1'b1, fill(8'hFF), 8);
        idle(1);
        step(3'b010, 1'b0, fill(8'd2));
        step(3'b010, 1'b1, fill(8'd2));
        idle(4);

        // Aborted load leaves bank 0 untouched.
        load_seq(1'b0, fill(8'd9), 4);
        idle(1);
        step(3'b010, 1'b0, fill(8'd3));
        idle(4);

        // Load together with execute: no MAC, accumulator unchanged.
        step(3'b011, 1'b0, fill(8'd3));
        step(3'b111, 1'b0, fill(8'd3));
        idle(4);
        step(3'b110, 1'b0, fill(8'd3));
        idle(4);

        // Execute immediately after the capturing load cycle sees the new key.
        load_seq(1'b1, fill(8'd4), 6);
        step(3'b010, 1'b1, fill(8'd1));
        idle(4);

        // Asynchronous reset in the middle of an execute stream.
        for (int i = 0; i < 4; i++) step(3'b010, 1'b0, fill(8'd3));
        #2;
        reset  = 1'b0;
        i_inst = '0;
        #1;
        chk("midrst_out", {38'd0, out}, 64'd0);
        chk("midrst_fifo_wr", {63'd0, fifo_wr}, 64'd0);
        chk("midrst_q_out", q_out, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(6);
        chk("postrst_out", {38'd0, out}, 64'd0);

        // Repeated max-positive psum: clamp with the feature, wrap without.
        load_seq(1'b0, fill(8'h80), 8);
        idle(1);
        step(3'b010, 1'b0, fill(8'h80));
        for (int i = 0; i < 259; i++) step(3'b110, 1'b0, fill(8'h80));
        idle(5);
        chk("o_sat", {63'd0, o_sat}, {63'd0, m_sat});
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
